// File: rtl/ptg_pkg.sv
// Shared types and constants for the pulse train generator.
package ptg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } ptg_state_t;

  localparam int MIN_LOW = 1;

endpackage

// File: rtl/ptg_phase_counter.sv
// Load/decrement down-counter with a zero flag; times both the high and low phases.
module ptg_phase_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Saturates at zero so a stray decrement can never wrap to a huge phase.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Pulse train generator: N pulses of H cycles separated by max(L,1) low cycles.
// Defining PTG_ABORT_EN adds an abort input that terminates a running train.
module pulse_train_gen
  import ptg_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int NUM_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] high_cycles,
  input  logic [CNT_W-1:0] low_cycles,
  input  logic [NUM_W-1:0] num_pulses,
`ifdef PTG_ABORT_EN
  input  logic             abort,
`endif
  output logic             pulse_out,
  output logic             busy,
  output logic             done
);

  ptg_state_t       state;
  ptg_state_t       state_next;
  logic [CNT_W-1:0] high_lat;
  logic [CNT_W-1:0] low_lat;
  logic [NUM_W-1:0] pulse_cnt;
  logic             launch_ok;
  logic             launch;
  logic             zero_job;
  logic             abort_req;
  logic             last_pulse;
  logic             phase_load;
  logic             phase_dec;
  logic             phase_zero;
  logic [CNT_W-1:0] phase_value;
  logic [CNT_W-1:0] low_load;
  logic             pulse_d;
  logic             busy_d;
  logic             done_d;

`ifdef PTG_ABORT_EN
  assign abort_req = abort && (state != IDLE);
`else
  assign abort_req = 1'b0;
`endif

  assign launch_ok  = (high_cycles != '0) && (num_pulses != '0);
  assign launch     = (state == IDLE) && start && launch_ok;
  assign zero_job   = (state == IDLE) && start && !launch_ok;
  assign last_pulse = (pulse_cnt == '0);
  // A low width of 0 still needs one low cycle to produce a separate rising edge.
  assign low_load   = (low_lat < CNT_W'(MIN_LOW)) ? CNT_W'(MIN_LOW - 1)
                                                  : low_lat - CNT_W'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (launch) begin
          state_next = HIGH;
        end
      end
      HIGH: begin
        if (abort_req) begin
          state_next = IDLE;
        end else if (phase_zero) begin
          state_next = last_pulse ? IDLE : LOW;
        end
      end
      LOW: begin
        if (abort_req) begin
          state_next = IDLE;
        end else if (phase_zero) begin
          state_next = HIGH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are the registered image of the next state, so pulse_out is glitch-free.
  always_comb begin
    pulse_d     = (state_next == HIGH);
    busy_d      = (state_next != IDLE);
    done_d      = ((state != IDLE) && (state_next == IDLE)) || zero_job;
    phase_load  = 1'b0;
    phase_dec   = 1'b0;
    phase_value = '0;
    if (launch) begin
      phase_load  = 1'b1;
      phase_value = high_cycles - CNT_W'(1);
    end else if ((state == LOW) && (state_next == HIGH)) begin
      phase_load  = 1'b1;
      phase_value = high_lat - CNT_W'(1);
    end else if ((state == HIGH) && (state_next == LOW)) begin
      phase_load  = 1'b1;
      phase_value = low_load;
    end else if (state != IDLE) begin
      phase_dec = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      high_lat  <= '0;
      low_lat   <= '0;
      pulse_cnt <= '0;
    end else if (launch) begin
      high_lat  <= high_cycles;
      low_lat   <= low_cycles;
      pulse_cnt <= num_pulses - NUM_W'(1);
    end else if ((state == HIGH) && (state_next == LOW)) begin
      pulse_cnt <= pulse_cnt - NUM_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pulse_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      pulse_out <= pulse_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  ptg_phase_counter #(
    .CNT_W(CNT_W)
  ) u_phase (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (phase_load),
    .load_value(phase_value),
    .dec       (phase_dec),
    .zero      (phase_zero)
  );

endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen: train-level reference model, per-cycle compare and pinned waveforms.
// Abort scenarios are exercised when PTG_ABORT_EN is defined.
module tb_pulse_train_gen;

  localparam int CNT_W = 8;
  localparam int NUM_W = 8;
  localparam int HIST  = 16384;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] high_cycles = '0;
  logic [CNT_W-1:0] low_cycles = '0;
  logic [NUM_W-1:0] num_pulses = '0;
`ifdef PTG_ABORT_EN
  logic             abort = 1'b0;
`endif
  logic             pulse_out;
  logic             busy;
  logic             done;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  // The model describes the current train as start cycle, busy length, H and effective L.
  bit tr_live = 1'b0;
  int tr_start = 0;
  int tr_len = 0;
  int tr_h = 1;
  int tr_lm = 1;

  bit hist_p [HIST];
  bit hist_b [HIST];
  bit hist_d [HIST];

  pulse_train_gen #(
    .CNT_W(CNT_W),
    .NUM_W(NUM_W)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .high_cycles(high_cycles),
    .low_cycles (low_cycles),
    .num_pulses (num_pulses),
`ifdef PTG_ABORT_EN
    .abort      (abort),
`endif
    .pulse_out  (pulse_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic bit m_busy(input int c);
    return tr_live && (c > tr_start) && (c <= tr_start + tr_len);
  endfunction

  function automatic bit m_pulse(input int c);
    if (!m_busy(c)) return 1'b0;
    return ((c - tr_start - 1) % (tr_h + tr_lm)) < tr_h;
  endfunction

  function automatic bit m_done(input int c);
    return tr_live && (c == tr_start + tr_len + 1);
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic modelStart(input int c, input int h, input int l, input int n);
    if (!m_busy(c)) begin
      tr_live  = 1'b1;
      tr_start = c;
      tr_h     = h;
      tr_lm    = (l == 0) ? 1 : l;
      tr_len   = (h == 0 || n == 0) ? 0 : n * h + (n - 1) * tr_lm;
    end
  endtask

  task automatic modelAbort(input int c);
    if (m_busy(c)) tr_len = c - tr_start;
  endtask

  always @(negedge clock) begin
    if (cyc < HIST) begin
      hist_p[cyc] = pulse_out;
      hist_b[cyc] = busy;
      hist_d[cyc] = done;
    end
    if (check_en) begin
      checkOutput("model_pulse_out", int'(pulse_out), int'(m_pulse(cyc)));
      checkOutput("model_busy", int'(busy), int'(m_busy(cyc)));
      checkOutput("model_done", int'(done), int'(m_done(cyc)));
    end
  end

  task automatic stepCycle();
    @(negedge clock);
    #1;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) stepCycle();
  endtask

  // Holds start for one cycle; on return the bench sits in cycle k+1.
  task automatic applyStimulus(input int h, input int l, input int n, output int k);
    high_cycles = CNT_W'(h);
    low_cycles  = CNT_W'(l);
    num_pulses  = NUM_W'(n);
    start       = 1'b1;
    k           = cyc;
    modelStart(k, h, l, n);
    stepCycle();
    start = 1'b0;
  endtask

  task automatic checkWindow(input string name, input int k, input int len, input int exp);
    int act;
    act = 0;
    for (int i = 0; i < len; i++) act = (act << 1) | int'(hist_p[k + 1 + i]);
    checkOutput(name, act, exp);
  endtask

  initial begin
    int k;
    int k2;
    int guard;
    int cnt;
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    int k2;
    int guard;
    int cnt;
    int h;
    int l;
    int n;

    repeat (3) @(negedge clock);
    #1;
    checkOutput("reset_pulse_out", int'(pulse_out), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    reset_n  = 1'b1;
    check_en = 1'b1;
    waitCycles(2);

    applyStimulus(3, 2, 1, k);
    waitCycles(5);
    checkWindow("single_pulse", k, 4, 'b1110);
    checkOutput("single_done_k4", int'(hist_d[k + 4]), 1);
    checkOutput("single_done_k3", int'(hist_d[k + 3]), 0);
    checkOutput("single_busy_k3", int'(hist_b[k + 3]), 1);
    checkOutput("single_busy_k4", int'(hist_b[k + 4]), 0);

    applyStimulus(2, 3, 3, k);
    waitCycles(14);
    checkWindow("train_h2l3n3", k, 13, 'b1100011000110);
    checkOutput("train_done_k13", int'(hist_d[k + 13]), 1);
    checkOutput("train_done_k12", int'(hist_d[k + 12]), 0);

    applyStimulus(1, 0, 4, k);
    waitCycles(9);
    checkWindow("low0_toggle", k, 8, 'b10101010);
    checkOutput("low0_done_k8", int'(hist_d[k + 8]), 1);

    applyStimulus(0, 3, 2, k);
    waitCycles(2);
    checkOutput("zero_h_done", int'(hist_d[k + 1]), 1);
    checkOutput("zero_h_busy", int'(hist_b[k + 1]), 0);
    checkOutput("zero_h_pulse", int'(hist_p[k + 1]), 0);
    applyStimulus(3, 1, 0, k);
    waitCycles(2);
    checkOutput("zero_n_done", int'(hist_d[k + 1]), 1);
    checkOutput("zero_n_busy", int'(hist_b[k + 1]), 0);

    applyStimulus(4, 2, 2, k);
    applyStimulus(1, 1, 1, k2);
    waitCycles(12);
    checkWindow("start_while_busy", k, 11, 'b11110011110);
    checkOutput("start_while_busy_done", int'(hist_d[k + 11]), 1);

    applyStimulus(2, 1, 2, k);
    guard = 0;
    while (cyc != k + 6 && guard < 50) begin
      stepCycle();
      guard++;
    end
    checkOutput("b2b_wait_in_budget", int'(guard < 50), 1);
    applyStimulus(1, 1, 1, k2);
    waitCycles(4);
    checkOutput("b2b_first_done", int'(hist_d[k + 6]), 1);
    checkOutput("b2b_second_pulse", int'(hist_p[k + 7]), 1);
    checkOutput("b2b_second_busy", int'(hist_b[k + 7]), 1);
    checkOutput("b2b_second_done", int'(hist_d[k + 8]), 1);

    applyStimulus(5, 2, 3, k);
    waitCycles(2);
    reset_n = 1'b0;
    tr_live = 1'b0;
    #1;
    checkOutput("midreset_before_pulse", int'(hist_p[k + 3]), 1);
    checkOutput("midreset_pulse_out", int'(pulse_out), 0);
    checkOutput("midreset_busy", int'(busy), 0);
    checkOutput("midreset_done", int'(done), 0);
    waitCycles(2);
    reset_n = 1'b1;
    waitCycles(20);
    cnt = 0;
    for (int i = k + 3; i <= k + 25; i++) cnt += int'(hist_d[i]);
    checkOutput("midreset_no_done", cnt, 0);

    applyStimulus(255, 1, 2, k);
    waitCycles(515);
    checkOutput("maxh_pulse_k255", int'(hist_p[k + 255]), 1);
    checkOutput("maxh_pulse_k256", int'(hist_p[k + 256]), 0);
    checkOutput("maxh_done_k512", int'(hist_d[k + 512]), 1);

`ifdef PTG_ABORT_EN
    applyStimulus(3, 4, 3, k);
    waitCycles(4);
    abort = 1'b1;
    modelAbort(cyc);
    stepCycle();
    abort = 1'b0;
    waitCycles(3);
    checkOutput("abort_low_pulse_k5", int'(hist_p[k + 5]), 0);
    checkOutput("abort_done_k6", int'(hist_d[k + 6]), 1);
    checkOutput("abort_busy_k6", int'(hist_b[k + 6]), 0);
    checkOutput("abort_pulse_k6", int'(hist_p[k + 6]), 0);
`endif

    for (int it = 0; it < 3000; it++) begin
      stepCycle();
      h = $urandom_range(0, 5);
      l = $urandom_range(0, 4);
      n = $urandom_range(0, 4);
      high_cycles = CNT_W'(h);
      low_cycles  = CNT_W'(l);
      num_pulses  = NUM_W'(n);
`ifdef PTG_ABORT_EN
      abort = ($urandom_range(0, 29) == 0);
      if (abort) modelAbort(cyc);
`endif
      start = ($urandom_range(0, 3) == 0);
      if (start) modelStart(cyc, h, l, n);
    end
    stepCycle();
    start = 1'b0;
`ifdef PTG_ABORT_EN
    abort = 1'b0;
`endif
    waitCycles(60);

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
